// File: rtl/arbiter_stream_mux.sv
// Per-packet round-robin arbiter/mux onto one valid/ready stream.
// Optional stall watchdog enabled by defining ARBITER_WATCHDOG_EN.
module arbiter_stream_mux #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data,
  input  logic [0:NUM_PORTS-1]            up_valid,
  input  logic [0:NUM_PORTS-1]            up_last,
  output logic [0:NUM_PORTS-1]            up_ready,
  output logic [DATA_WIDTH-1:0]           dn_data,
  output logic                            dn_valid,
  output logic                            dn_last,
  input  logic                            dn_ready,
  output logic [0:NUM_PORTS-1]            grant,
  output logic                            active,
  output logic                            timeout
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [0:NUM_PORTS-1] grant_q, grant_d;
  logic                 timeout_q, timeout_d;
  logic [IW-1:0]        pick;
  logic                 found;
  logic                 busy;
  logic                 own_valid;
  logic                 xfer_last;
  logic                 wd_fire;
  int                   idx;

  // Search starts just after the last-served port.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && up_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign own_valid = up_valid[own_q];
  assign dn_data   = up_data[own_q*DATA_WIDTH +: DATA_WIDTH];
  assign dn_valid  = busy & own_valid;
  assign dn_last   = busy & up_last[own_q];
  assign xfer_last = dn_valid & dn_ready & dn_last;

  always_comb begin
    up_ready = '0;
    if (busy) up_ready[own_q] = dn_ready;
  end

`ifdef ARBITER_WATCHDOG_EN
  logic [7:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (busy && !own_valid) begin
      wd_d    = wd_q + 8'd1;
      wd_fire = (wd_d == 8'(TIMEOUT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          own_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        // A last-beat transfer wins over a same-cycle watchdog expiry.
        if (xfer_last || wd_fire) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = own_q;
          timeout_d = ~xfer_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      own_q     <= '0;
      ptr_q     <= IW'(NUM_PORTS - 1);
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign active  = busy;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Cycle-by-cycle vector bench for arbiter_stream_mux.
// Watchdog vectors run only when ARBITER_WATCHDOG_EN is defined.
module tb_arbiter_stream_mux;

  localparam int NP = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] up_data;
  logic [0:NP-1]    up_valid;
  logic [0:NP-1]    up_last;
  logic [0:NP-1]    up_ready;
  logic [DW-1:0]    dn_data;
  logic             dn_valid;
  logic             dn_last;
  logic             dn_ready;
  logic [0:NP-1]    grant;
  logic             active;
  logic             timeout;

  int n_chk  = 0;
  int n_fail = 0;

  arbiter_stream_mux #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .TIMEOUT   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .up_data (up_data),
    .up_valid(up_valid),
    .up_last (up_last),
    .up_ready(up_ready),
    .dn_data (dn_data),
    .dn_valid(dn_valid),
    .dn_last (dn_last),
    .dn_ready(dn_ready),
    .grant   (grant),
    .active  (active),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [0:NP-1] uv;
    logic [0:NP-1] ul;
    logic          dr;
    logic [7:0]    beat;
    logic [0:NP-1] eg;
    logic          ea;
    logic          edv;
    logic          edl;
    logic [0:NP-1] eur;
    logic [1:0]    eown;
    logic          eto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic [0:NP-1] uv, logic [0:NP-1] ul,
    logic dr, logic [7:0] b, logic [0:NP-1] eg,
    logic ea, logic edv, logic edl,
    logic [0:NP-1] eur, logic [1:0] eo, logic eto);
    vec_t v;
    v.rst = r;   v.uv = uv;   v.ul = ul;
    v.dr = dr;   v.beat = b;  v.eg = eg;
    v.ea = ea;   v.edv = edv; v.edl = edl;
    v.eur = eur; v.eown = eo; v.eto = eto;
    return v;
  endfunction

  // Idle-cycle record: nothing owned, all outputs quiet.
  function automatic vec_t idl(logic r, logic [0:NP-1] uv);
    return mk(r, uv, 4'b0, 1'b1, 8'd0,
              4'b0, 0, 0, 0, 4'b0, 2'd0, 0);
  endfunction

  // Busy-cycle record for owner o.
  function automatic vec_t bsy(
    logic r, logic [0:NP-1] uv, logic [0:NP-1] ul,
    logic dr, logic [7:0] b, logic [1:0] o,
    logic edv, logic edl);
    logic [0:NP-1] g;
    logic [0:NP-1] ur;
    g = '0;
    g[o] = 1'b1;
    ur = '0;
    ur[o] = dr;
    return mk(r, uv, ul, dr, b, g, 1, edv, edl, ur, o, 0);
  endfunction

  task automatic chk(string nm, int i,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h",
               nm, i, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int i);
    @(posedge clk);
    #1;
    rst      = v.rst;
    up_valid = v.uv;
    up_last  = v.ul;
    dn_ready = v.dr;
    for (int p = 0; p < NP; p++)
      up_data[p*DW +: DW] = {16'hD0D0, 8'(p), v.beat};
    #3;
    chk("grant", i, 32'(grant), 32'(v.eg));
    chk("active", i, 32'(active), 32'(v.ea));
    chk("dn_valid", i, 32'(dn_valid), 32'(v.edv));
    chk("dn_last", i, 32'(dn_last), 32'(v.edl));
    chk("up_ready", i, 32'(up_ready), 32'(v.eur));
    chk("timeout", i, 32'(timeout), 32'(v.eto));
    if (v.edv)
      chk("dn_data", i, dn_data,
          {16'hD0D0, 8'(v.eown), v.beat});
  endtask

  initial begin
    rst      = 1'b1;
    up_valid = '0;
    up_last  = '0;
    dn_ready = 1'b0;
    up_data  = '0;
    repeat (2) @(posedge clk);

    // reset state, then port 2 sends 3 beats
    tbl.push_back(idl(0, 4'b0000));
    tbl.push_back(idl(0, 4'b0010));
    tbl.push_back(bsy(0, 4'b0010, 4'b0000, 1, 1, 2, 1, 0));
    tbl.push_back(bsy(0, 4'b0010, 4'b0000, 1, 2, 2, 1, 0));
    tbl.push_back(bsy(0, 4'b0010, 4'b0010, 1, 3, 2, 1, 1));
    tbl.push_back(idl(0, 4'b0000));
    // reset so port 0 is first; ports 0,1,3 two beats each
    tbl.push_back(idl(1, 4'b0000));
    tbl.push_back(idl(0, 4'b1101));
    tbl.push_back(bsy(0, 4'b1101, 4'b0000, 1, 1, 0, 1, 0));
    tbl.push_back(bsy(0, 4'b1101, 4'b1000, 1, 2, 0, 1, 1));
    tbl.push_back(idl(0, 4'b0101));
    tbl.push_back(bsy(0, 4'b1101, 4'b0000, 1, 1, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b1101, 4'b0100, 1, 2, 1, 1, 1));
    tbl.push_back(idl(0, 4'b1101));
    tbl.push_back(bsy(0, 4'b1101, 4'b0000, 1, 1, 3, 1, 0));
    tbl.push_back(bsy(0, 4'b1101, 4'b0001, 1, 2, 3, 1, 1));
    tbl.push_back(idl(0, 4'b1000));
    tbl.push_back(bsy(0, 4'b1000, 4'b0000, 1, 1, 0, 1, 0));
    tbl.push_back(bsy(0, 4'b1000, 4'b1000, 1, 2, 0, 1, 1));
    tbl.push_back(idl(0, 4'b0000));
    // port 1, 4 beats, dn_ready 1,0,0,1; port 3 waiting
    tbl.push_back(idl(0, 4'b0101));
    tbl.push_back(bsy(0, 4'b0101, 4'b0000, 1, 1, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b0101, 4'b0000, 0, 2, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b0101, 4'b0000, 0, 2, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b0101, 4'b0000, 1, 2, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b0101, 4'b0000, 1, 3, 1, 1, 0));
    tbl.push_back(bsy(0, 4'b0101, 4'b0100, 1, 4, 1, 1, 1));
    // port 3 single-beat packet
    tbl.push_back(idl(0, 4'b0001));
    tbl.push_back(bsy(0, 4'b0001, 4'b0001, 1, 1, 3, 1, 1));
    // port 0 gaps 5 cycles while port 1 requests
    tbl.push_back(idl(0, 4'b1000));
    tbl.push_back(bsy(0, 4'b1000, 4'b0000, 1, 1, 0, 1, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(bsy(0, 4'b0100, 4'b0000, 1, 2, 0, 0, 0));
    tbl.push_back(bsy(0, 4'b1100, 4'b1000, 1, 2, 0, 1, 1));
    tbl.push_back(idl(0, 4'b0100));
    tbl.push_back(bsy(0, 4'b0100, 4'b0100, 1, 1, 1, 1, 1));
    // reset during beat 2 of port 2's packet
    tbl.push_back(idl(0, 4'b1010));
    tbl.push_back(bsy(0, 4'b1010, 4'b0000, 1, 1, 2, 1, 0));
    tbl.push_back(bsy(1, 4'b1010, 4'b0000, 1, 2, 2, 1, 0));
    tbl.push_back(idl(0, 4'b1010));
    tbl.push_back(bsy(0, 4'b1010, 4'b1000, 1, 1, 0, 1, 1));
    tbl.push_back(idl(0, 4'b0000));
`ifdef ARBITER_WATCHDOG_EN
    // port 1 stalls 16 cycles, port 2 pending
    tbl.push_back(idl(0, 4'b0110));
    tbl.push_back(bsy(0, 4'b0110, 4'b0000, 1, 1, 1, 1, 0));
    for (int k = 0; k < 16; k++)
      tbl.push_back(bsy(0, 4'b0010, 4'b0000, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0000, 1, 0,
                     4'b0, 0, 0, 0, 4'b0, 2'd0, 1));
    tbl.push_back(bsy(0, 4'b0010, 4'b0010, 1, 1, 2, 1, 1));
    tbl.push_back(idl(0, 4'b0000));
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
